// File: rtl/lopaz_srpad.sv
// Registered bidirectional pad slice: registered output data/enable drive a shared
// tri-state bus; the input path keeps a two-sample history with optional loopback.

module lopaz_srpad_lane (
  input  logic clk,
  input  logic reset,
  input  logic d_out,
  input  logic pad,
  input  logic foo,
  output logic out_q,
  output logic s0,
  output logic s1
);
  // Loopback takes out_q as held before the edge, so it works with the pad tri-stated.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 1'b0;
      s0    <= 1'b0;
      s1    <= 1'b0;
    end else begin
      out_q <= d_out;
      s0    <= foo ? out_q : pad;
      s1    <= s0;
    end
  end
endmodule

module lopaz_srpad #(
  parameter int w = 4
) (
  input  logic           clk,
  input  logic           reset,
  inout  wire  [w-1:0]   pin,
  input  logic [w-1:0]   pin_out,
  input  logic           pin_outen,
  input  logic           foo,
  output logic [2*w-1:0] pin_in
);
  logic         oe_q;
  logic [w-1:0] out_q, s0, s1;

  always_ff @(posedge clk) begin
    if (reset) oe_q <= 1'b0;
    else       oe_q <= pin_outen;
  end

  for (genvar i = 0; i < w; i++) begin : g_lane
    lopaz_srpad_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .d_out (pin_out[i]),
      .pad   (pin[i]),
      .foo   (foo),
      .out_q (out_q[i]),
      .s0    (s0[i]),
      .s1    (s1[i])
    );
  end

  assign pin    = oe_q ? out_q : {w{1'bz}};
  assign pin_in = {s1, s0};
endmodule

// File: tb/tb_lopaz_srpad.sv
// Scoreboard bench for lopaz_srpad: directed scenarios plus random traffic, each edge's
// expected outputs queued by a behavioural model and checked by an independent monitor.

module tb_lopaz_srpad;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   pin_out = '0;
  logic           pin_outen = 1'b0;
  logic           foo = 1'b0;
  logic [2*W-1:0] pin_in;
  logic [W-1:0]   drv = '0;
  logic           drv_en = 1'b0;
  wire  [W-1:0]   pin;

  assign pin = drv_en ? drv : {W{1'bz}};

  lopaz_srpad #(.w(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .pin       (pin),
    .pin_out   (pin_out),
    .pin_outen (pin_outen),
    .foo       (foo),
    .pin_in    (pin_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    logic [2*W-1:0] pin_in;
    bit             chk_pin;
    logic [W-1:0]   pin;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: what the pad holds and what it has sampled so far.
  logic [W-1:0] m_out = '0;
  bit           m_oe  = 1'b0;
  logic [W-1:0] hist[$];

  function automatic logic [W-1:0] hist_at(int back);
    if (hist.size() > back) return hist[hist.size()-1-back];
    return '0;
  endfunction

  task automatic step(string tag, bit rst, logic [W-1:0] po, bit oe, bit lb, logic [W-1:0] ext);
    logic [W-1:0] pad_val;
    exp_t e;
    @(negedge clk);
    reset     = rst;
    pin_out   = po;
    pin_outen = oe;
    foo       = lb;
    drv       = ext;
    drv_en    = !m_oe;
    if (rst) begin
      m_out = '0;
      m_oe  = 1'b0;
      hist.delete();
    end else begin
      pad_val = m_oe ? m_out : ext;
      hist.push_back(lb ? m_out : pad_val);
      if (hist.size() > 2) void'(hist.pop_front());
      m_out = po;
      m_oe  = oe;
    end
    e.tag     = tag;
    e.pin_in  = {hist_at(1), hist_at(0)};
    e.chk_pin = m_oe || drv_en;
    e.pin     = m_oe ? m_out : ext;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (m_oe) drv_en = 1'b0;
  endtask

  // Monitor: every edge is a transfer; compare once the outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pin_in !== e.pin_in) begin
          errors++;
          $display("FAIL %s pin_in: got %h expected %h", e.tag, pin_in, e.pin_in);
        end
        if (e.chk_pin) begin
          checks++;
          if (pin !== e.pin) begin
            errors++;
            $display("FAIL %s pin: got %b expected %b", e.tag, pin, e.pin);
          end
        end
      end
    end
  end

  initial begin
    int budget;
    // Reset held with output requested; pad must stay released while reset is high.
    step("reset0", 1, 4'hF, 1, 0, 4'h2);
    step("reset1", 1, 4'hF, 1, 0, 4'h4);
    step("reset_rel", 0, 4'hF, 1, 0, 4'h0);
    // Drive latency and tri-state
    step("drive_a", 0, 4'hA, 1, 0, 4'h0);
    step("drive_5", 0, 4'h5, 1, 0, 4'h0);
    step("tristate", 0, 4'h5, 0, 0, 4'h0);
    // Input capture from an external driver
    step("cap_idle", 0, 4'h0, 0, 0, 4'h1);
    step("cap_3", 0, 4'h0, 0, 0, 4'h3);
    step("cap_c", 0, 4'h0, 0, 0, 4'hC);
    step("cap_7", 0, 4'h0, 0, 0, 4'h7);
    // Loopback ignores the pad
    step("lb_9", 0, 4'h9, 0, 1, 4'h0);
    step("lb_hold", 0, 4'h9, 0, 1, 4'h0);
    step("lb_next", 0, 4'h2, 0, 1, 4'hE);
    // Self-read of the driven pad
    step("self_6", 0, 4'h6, 1, 0, 4'h0);
    step("self_hold", 0, 4'h6, 1, 0, 4'h0);
    step("self_next", 0, 4'h1, 1, 0, 4'h0);
    // Mid-operation reset pulse
    step("stream_b", 0, 4'hB, 1, 0, 4'h0);
    step("stream_d", 0, 4'hD, 1, 0, 4'h0);
    step("mid_rst", 1, 4'h8, 1, 0, 4'h0);
    step("resume", 0, 4'h8, 1, 0, 4'h0);
    step("resume2", 0, 4'h3, 1, 0, 4'h0);
    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), W'($urandom), bit'($urandom),
           ($urandom_range(0, 3) == 0), W'($urandom));
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
